// File: rtl/fifo_ser_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ser_pkg
// Shared definitions for the FIFO-to-serial framer: the FSM state type, the
// serial line levels and a helper that sizes the baud counter.
// -----------------------------------------------------------------------------
package fifo_ser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        START,
        DATA,
        STOP
    } ser_state_t;

    localparam logic TX_IDLE   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // A divide-by-one timer still needs a one-bit counter to stay legal.
    function automatic int baud_cnt_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/fifo_serializer_if.sv
// -----------------------------------------------------------------------------
// fifo_serializer_if
// Bundles the FIFO read port, the enable input and the serial-side outputs of
// the serializer.
//   master : the serializer (drives fifo_read, tx_out, busy, word_done)
//   slave  : the surrounding FIFO / link logic (drives enable, fifo_empty,
//            fifo_data_out)
// -----------------------------------------------------------------------------
interface fifo_serializer_if #(
    parameter int width = 16
);

    logic             enable;
    logic             fifo_empty;
    logic [width-1:0] fifo_data_out;
    logic             fifo_read;
    logic             tx_out;
    logic             busy;
    logic             word_done;

    modport master (
        input  enable,
        input  fifo_empty,
        input  fifo_data_out,
        output fifo_read,
        output tx_out,
        output busy,
        output word_done
    );

    modport slave (
        output enable,
        output fifo_empty,
        output fifo_data_out,
        input  fifo_read,
        input  tx_out,
        input  busy,
        input  word_done
    );

endinterface

// File: rtl/bit_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
// Baud counter for the serializer. Counts clock cycles while 'run' is high and
// pulses 'tick' on the last cycle of every bit period.
//   clk, rst : clock and asynchronous active-high reset
//   clear    : restart the bit period from zero (wins over run)
//   run      : advance the counter this cycle
//   tick     : last cycle of the current bit period
// -----------------------------------------------------------------------------
module bit_timer
    import fifo_ser_pkg::*;
#(
    parameter int clks_per_bit = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int               CNT_W = baud_cnt_width(clks_per_bit);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(clks_per_bit - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_serializer.sv
// -----------------------------------------------------------------------------
// fifo_serializer
// Pops one word at a time from a synchronous FIFO and sends it on tx_out as
// a start bit, the data MSB first, and a stop bit, each held for clks_per_bit
// clocks.
//   clk, rst           : clock and asynchronous active-high reset
//   bus.enable         : allows a new frame to start (looked at only in IDLE)
//   bus.fifo_empty     : FIFO empty flag
//   bus.fifo_data_out  : FIFO read data, valid the cycle after fifo_read
//   bus.fifo_read      : one-cycle read pulse per word
//   bus.tx_out         : registered serial line, idles high
//   bus.busy           : high whenever the FSM is not in IDLE
//   bus.word_done      : one-cycle pulse after a stop bit completes
// -----------------------------------------------------------------------------
module fifo_serializer
    import fifo_ser_pkg::*;
#(
    parameter int width        = 16,
    parameter int clks_per_bit = 4
) (
    input  logic               clk,
    input  logic               rst,
    fifo_serializer_if.master  bus
);

    localparam int                   BIT_CNT_W = $clog2(width) + 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(width - 1);

    ser_state_t           state_q;
    ser_state_t           state_d;
    logic [width-1:0]     shift_q;
    logic [width-1:0]     shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [BIT_CNT_W-1:0] bit_cnt_d;
    logic                 tx_q;
    logic                 tx_d;
    logic                 word_done_q;
    logic                 word_done_d;
    logic                 timer_clear;
    logic                 timer_run;
    logic                 tick;

    // The bit period restarts in LOAD so the start bit gets a full period.
    assign timer_clear = (state_q == LOAD);
    assign timer_run   = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    bit_timer #(
        .clks_per_bit(clks_per_bit)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .run   (timer_run),
        .tick  (tick)
    );

    // The read pulse is gated by fifo_empty so an empty FIFO is never popped.
    assign bus.fifo_read = (state_q == READ) && !bus.fifo_empty;
    assign bus.tx_out    = tx_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.word_done = word_done_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        word_done_d = 1'b0;
        tx_d        = TX_IDLE;

        case (state_q)
            IDLE: begin
                if (bus.enable && !bus.fifo_empty) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = bus.fifo_empty ? IDLE : LOAD;
            end
            LOAD: begin
                shift_d   = bus.fifo_data_out;
                bit_cnt_d = '0;
                state_d   = START;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = {shift_q[width-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d     = IDLE;
                    word_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The line level is derived from the next state so tx_out comes
        // straight from a flop and lines up with the state it belongs to.
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shift_d[width-1];
            STOP:    tx_d = STOP_BIT;
            default: tx_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            tx_q        <= TX_IDLE;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            word_done_q <= word_done_d;
        end
    end

endmodule

// File: doc/fifo_serializer.md
Name: fifo_serializer

Overview:
- Downstream consumer of the team's synchronous FIFO. It pops one word at a time through the FIFO read port (fifo_read / fifo_empty / fifo_data_out).
- Each word is sent as a framed bit-serial stream on tx_out: start bit, data MSB-first, stop bit, each bit held a fixed number of clocks.
- Sits between the FIFO buffer and an off-block serial link.

Parameters:
- width, 16, data word width; must match the FIFO width.
- clks_per_bit, 4, clock cycles per serial bit; legal range ≥1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset: asynchronous, active-high.
- enable  input  1  permits starting a new frame; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data_out  input  width  FIFO registered read data; valid the cycle after a read pulse.
- fifo_read  output  1  FIFO read request; one-cycle pulse per word.
- tx_out  output  1  serial line; idles high.
- busy  output  1  high whenever state ≠ IDLE.
- word_done  output  1  one-cycle pulse after a frame's stop bit completes.

Behaviour:
- Reset values (immediate, asynchronous, also mid-frame):
  - tx_out=1, fifo_read=0, busy=0, word_done=0.
  - state=IDLE; shift register, bit counter and baud counter all 0.
  - A partial frame is abandoned; no word_done is produced for it.
- FSM states: IDLE, READ, LOAD, START, DATA, STOP.
- IDLE: if enable && !fifo_empty, go to READ; otherwise stay.
- READ:
  - fifo_read = (state==READ) && !fifo_empty. This is combinational from the state register, for exactly one cycle.
  - If fifo_empty, return to IDLE with no pulse; otherwise go to LOAD.
- LOAD: capture fifo_data_out into the shift register, clear the baud counter, go to START.
- START: tx_out=0 for clks_per_bit cycles, then DATA.
- DATA:
  - tx_out = shift register MSB.
  - Every clks_per_bit cycles, shift left by 1 and increment bit_cnt.
  - After width bits, go to STOP.
- STOP: tx_out=1 for clks_per_bit cycles, then go to IDLE with word_done=1 for that single IDLE cycle.
- tx_out is a registered output; no combinational path from inputs to tx_out.
- Latency: enable && !empty seen in IDLE at cycle 0 → fifo_read in cycle 1 → capture in cycle 2 → tx_out falls in cycle 3.
- Frame length: (width+2)*clks_per_bit cycles.
- Gap between back-to-back frames: 3 extra high cycles after the stop bit (IDLE, READ, LOAD).
- Counter widths:
  - baud counter: max($clog2(clks_per_bit),1) bits, wraps at clks_per_bit-1.
  - bit counter: $clog2(width)+1 bits.
  - No overflow is possible.
- Boundary conditions:
  - enable dropped mid-frame: the current frame completes normally; no new read.
  - fifo_empty asserting mid-frame: ignored.
  - clks_per_bit=1: one cycle per bit; all rules unchanged.
  - Never more than one fifo_read per frame. Never a read while the FIFO is empty.

Decomposition:
- Package fifo_ser_pkg:
  - typedef enum logic [2:0] ser_state_t {IDLE, READ, LOAD, START, DATA, STOP}.
  - localparam TX_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
- Sub-module bit_timer:
  - Parameterized by clks_per_bit.
  - Inputs clear and run; output tick pulses on the last cycle of each bit period.
  - Used by START, DATA and STOP.

Test Plan (width=16, clks_per_bit=4, paired with a real FIFO instance):
1. Reset: assert rst mid-simulation → tx_out=1, fifo_read=0, busy=0, word_done=0 in the same cycle, before the next clock edge.
2. Single word 16'hA5C3, enable=1:
   - Exactly one fifo_read pulse; tx_out low for 4 cycles starting at cycle 3.
   - Then bits 1010_0101_1100_0011, 4 cycles each; then high for 4 cycles.
   - word_done pulses once, 72 cycles after the start bit begins; FIFO returns empty.
3. Empty FIFO, enable=1 for 100 cycles → fifo_read never asserts, tx_out stays 1, busy=0.
4. Three words 16'h0001, 16'h8000, 16'hFFFF back-to-back:
   - Exactly 3 fifo_read pulses and 3 word_done pulses.
   - Each inter-frame high gap is 4+3=7 cycles.
   - Decoded words match in order.
5. enable dropped at cycle 20 of a frame → frame completes with its word_done; no further fifo_read although the FIFO holds 2 words. Re-raise enable → the next word is sent.
6. rst pulsed during DATA bit 7:
   - tx_out=1 immediately; no word_done for the abandoned frame.
   - After release, with the FIFO non-empty and enable=1, the next word is read and a full frame is sent.
